// File: rtl/stream_demux_1to2_if.sv
// Handshake bundle for the 1-to-2 stream demux: one source port, two sink ports.
// master = source/sink side (bench), slave = the demux itself.
interface stream_demux_1to2_if;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out2_data;
    logic        out2_valid;
    logic        out2_ready;

    modport master (
        output in_data, in_sel, in_valid, out1_ready, out2_ready,
        input  in_ready, out1_data, out1_valid, out2_data, out2_valid
    );
    modport slave (
        input  in_data, in_sel, in_valid, out1_ready, out2_ready,
        output in_ready, out1_data, out1_valid, out2_data, out2_valid
    );
endinterface

// File: rtl/stream_demux_1to2.sv
// 1-to-2 stream demux with a 2-entry FIFO per output; in_ready never depends on out*_ready.
// Optional DEMUX_CNT_EN adds per-output saturating pop counters with cnt_clr.
module stream_demux_lane (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        valid,
    output logic        full
`ifdef DEMUX_CNT_EN
    ,
    input  logic        cnt_clr,
    output logic [15:0] cnt
`endif
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]  state;
    logic [31:0] head, tail;

    // head is always the oldest word, so dout is a plain register output
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            head  <= 32'h0;
            tail  <= 32'h0;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    head  <= din;
                    state <= ONE;
                end
                ONE: case ({push, pop})
                    2'b10: begin tail <= din; state <= FULL;  end
                    2'b01: state <= EMPTY;
                    2'b11: head <= din;
                    default: ;
                endcase
                FULL: if (pop) begin
                    head  <= tail;
                    state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign dout  = head;
    assign valid = (state != EMPTY);
    assign full  = (state == FULL);

`ifdef DEMUX_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            cnt <= 16'h0;
        else if (pop && cnt != 16'hFFFF)
            cnt <= cnt + 16'h1;
    end
`endif
endmodule

module stream_demux_1to2 (
    input  logic                  clk,
    input  logic                  rst,
    stream_demux_1to2_if.slave    bus
`ifdef DEMUX_CNT_EN
    ,
    input  logic                  cnt_clr,
    output logic [15:0]           out1_cnt,
    output logic [15:0]           out2_cnt
`endif
);
    localparam int NUM_LANES = 2;
    localparam int VEC_W     = 32;

    logic [NUM_LANES-1:0][VEC_W-1:0] lane_data;
    logic [NUM_LANES-1:0]            lane_valid, lane_ready, lane_full, lane_push, lane_pop;
    logic                            in_ready;
`ifdef DEMUX_CNT_EN
    logic [NUM_LANES-1:0][15:0]      lane_cnt;
`endif

    assign in_ready      = !lane_full[bus.in_sel];
    assign bus.in_ready  = in_ready;
    assign lane_ready    = {bus.out2_ready, bus.out1_ready};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_push[i] = bus.in_valid && in_ready && (bus.in_sel == 1'(i));
        assign lane_pop[i]  = lane_valid[i] && lane_ready[i];

        stream_demux_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .push    (lane_push[i]),
            .pop     (lane_pop[i]),
            .din     (bus.in_data),
            .dout    (lane_data[i]),
            .valid   (lane_valid[i]),
            .full    (lane_full[i])
`ifdef DEMUX_CNT_EN
            ,
            .cnt_clr (cnt_clr),
            .cnt     (lane_cnt[i])
`endif
        );
    end

    assign bus.out1_data  = lane_data[0];
    assign bus.out1_valid = lane_valid[0];
    assign bus.out2_data  = lane_data[1];
    assign bus.out2_valid = lane_valid[1];

`ifdef DEMUX_CNT_EN
    assign out1_cnt = lane_cnt[0];
    assign out2_cnt = lane_cnt[1];
`endif
endmodule

// File: doc/stream_demux_1to2.md
STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 SHALL have ports: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have ports: in_data  input  32  source word.
REQ-004 SHALL have ports: in_sel  input  1  steering: 0 -> out1, 1 -> out2.
REQ-005 SHALL have ports: in_valid  input  1  source word present; in_ready  output  1  word accepted this cycle if in_valid=1.
REQ-006 SHALL have ports: out1_data  output  32; out1_valid  output  1; out1_ready  input  1  (sink 1 handshake).
REQ-007 SHALL have ports: out2_data  output  32; out2_valid  output  1; out2_ready  input  1  (sink 2 handshake).
REQ-008 SHALL, when DEMUX_CNT_EN is defined, add: cnt_clr  input  1  clear counters; out1_cnt  output  16; out2_cnt  output  16.

Function
REQ-009 SHALL contain one 2-entry FIFO per output; occupancy states EMPTY(0), ONE(1), FULL(2).
REQ-010 SHALL drive in_ready = 1 iff the FIFO addressed by current in_sel is not FULL; no dependence on out*_ready (no full-cycle pass-through).
REQ-011 SHALL push in_data into the FIFO addressed by in_sel on a cycle with in_valid=1 and in_ready=1; the other FIFO unchanged.
REQ-012 SHALL pop a FIFO on a cycle where its outN_valid=1 and outN_ready=1.
REQ-013 SHALL present a pushed word on outN_data with outN_valid=1 no earlier than the cycle after acceptance; latency from acceptance to presentation into EMPTY FIFO is exactly 1 cycle.
REQ-014 SHALL preserve acceptance order per output; no ordering relation across outputs.
REQ-015 SHALL drive outN_valid = 1 iff FIFO N is not EMPTY; outN_data = oldest entry; outN_data and outN_valid held stable while outN_valid=1 and outN_ready=0.
REQ-016 SHALL transition: EMPTY+push -> ONE; ONE+push -> FULL; ONE+pop -> EMPTY; FULL+pop -> ONE; ONE+push+pop -> ONE (new word becomes sole entry); FULL+pop (no push possible) -> ONE; no event -> unchanged.
REQ-017 SHALL allow a push into one FIFO and pops from both FIFOs in the same cycle, all independent.
REQ-018 SHALL ignore in_data and in_sel when in_valid=0; in_sel may change freely while in_valid=0.
REQ-019 SHALL not drop or duplicate words; no overflow/underflow path exists.

Reset
REQ-020 SHALL, with rst=1 at a rising edge, set both FIFOs EMPTY, out1_valid=out2_valid=0, out1_data=out2_data=32'h0, in_ready=1 on the following cycle; stored words discarded.
REQ-021 SHALL give rst priority over push, pop and cnt_clr in the same cycle; a handshake coinciding with rst is not counted as a transfer.
REQ-022 SHALL, with DEMUX_CNT_EN, reset out1_cnt=out2_cnt=0.

Configuration
REQ-023 SHALL use macro DEMUX_CNT_EN: defined -> per-output 16-bit counters incremented on each pop of that output, saturating at 16'hFFFF, cleared to 0 by cnt_clr=1 (clear wins over increment); undefined -> counters, cnt_clr and outN_cnt ports absent, remaining behaviour identical.

Verification
REQ-024 SHALL cover: reset, then in_valid=1, in_sel=0, in_data=32'hDEADBEEF, out1_ready=1 -> out1_valid=1 with DEADBEEF exactly 1 cycle later, out2_valid stays 0.
REQ-025 SHALL cover: out2_ready=0, push 32'h1, 32'h2 with in_sel=1 -> in_ready=0 on third cycle with in_sel=1 but 1 with in_sel=0; release out2_ready -> out2 yields 1 then 2.
REQ-026 SHALL cover: out1 ONE holding 32'hA, same-cycle push 32'hB (in_sel=0) and pop -> out1_data=32'hB next cycle, state ONE.
REQ-027 SHALL cover: both FIFOs FULL, rst=1 for one cycle -> both valids 0, data 0, in_ready=1; no stale word later emerges.
REQ-028 SHALL cover (DEMUX_CNT_EN): 3 pops on out1 -> out1_cnt=3; force 16'hFFFF then pop -> stays FFFF; cnt_clr with pop -> 0.
